hazard_unit_param: RTL and testbench

- Parametrised successor to the 5-stage pipeline's hazard/forwarding logic.
- Resolves RAW hazards for NSRC source operands per instruction by forwarding from M and W.
- Inserts load-use bubbles, flushes on taken branches and on PC writes from the writeback path.
- Adds a multicycle execute unit (e.g. MUL) with a latency counter that holds the front of the pipe. Sits beside the datapath; drives stall/flush enables of the IFetch/IDecode/Exec pipeline registers and the E-stage operand muxes.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/mc_latency_ctr.sv | 45 ++++
 rtl/hazard_unit_param.sv | 112 +++++++++++
 tb/tb_hazard_unit_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the parametrised hazard / forwarding unit.
package hazard_pkg;

    localparam int RW_MAX = 8;

    typedef logic [RW_MAX-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    // A used source operand that names the destination of a writing stage.
    function automatic logic match(input reg_idx_t idx, input logic vld,
                                   input reg_idx_t rd, input logic we);
        return vld && we && (idx == rd);
    endfunction

endpackage

// File: rtl/mc_latency_ctr.sv
// Multicycle execute occupancy tracker: holds E for exactly MC_LAT cycles per op.
module mc_latency_ctr #(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_busy,
    output logic o_done
);
    import hazard_pkg::*;

    localparam int CW = $clog2(MC_LAT);

    mc_state_t      r_state;
    logic [CW-1:0]  r_cnt;

    // Start cycle counts as the first busy cycle, so the counter loads MC_LAT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MC_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= CW'(MC_LAT - 1);
                        r_state <= MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= MC_IDLE;
                    end
                end
                default: r_state <= MC_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == MC_BUSY) || i_start;
    assign o_done = (r_state == MC_BUSY) && (r_cnt == CW'(1));

endmodule

// File: rtl/hazard_unit_param.sv
// Hazard and forwarding control for the 5-stage pipe: operand forwarding,
// load-use bubbles, branch / PC-write flushes and multicycle-execute holds.
module hazard_unit_param #(
    parameter int RW     = 4,
    parameter int NSRC   = 3,
    parameter int MC_LAT = 4,
    parameter int PC_IDX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*RW-1:0]   src_idx_d,
    input  logic [NSRC-1:0]      src_vld_d,
    input  logic [NSRC*RW-1:0]   src_idx_e,
    input  logic [NSRC-1:0]      src_vld_e,
    input  logic [RW-1:0]        rd_e,
    input  logic                 regwrite_e,
    input  logic                 memtoreg_e,
    input  logic                 mc_start_e,
    input  logic [RW-1:0]        rd_m,
    input  logic                 regwrite_m,
    input  logic [RW-1:0]        rd_w,
    input  logic                 regwrite_w,
    input  logic                 pcsrc_d,
    input  logic                 pcsrc_e,
    input  logic                 pcsrc_m,
    input  logic                 pcsrc_w,
    input  logic                 branch_taken_e,
    output logic [NSRC*2-1:0]    fwd_sel_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 mc_busy,
    output logic                 mc_done
);
    import hazard_pkg::*;

    logic             w_mc_busy;
    logic             w_mc_done;
    logic [NSRC-1:0]  w_lu_hit;
    logic             w_ldstall;
    logic             w_pcpend;

    mc_latency_ctr #(
        .MC_LAT (MC_LAT)
    ) u_mc_ctr (
        .clk     (clk),
        .rst_n   (reset),
        .i_start (mc_start_e),
        .o_busy  (w_mc_busy),
        .o_done  (w_mc_done)
    );

    // Per-operand forward select (M beats W, PC never forwarded) and load-use compare.
    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [RW-1:0] w_idx_e;
        logic          w_use_e;
        fwd_sel_t      w_sel;

        assign w_idx_e = src_idx_e[k*RW +: RW];
        assign w_use_e = src_vld_e[k] && (w_idx_e != RW'(PC_IDX));

        always_comb begin
            w_sel = FWD_RF;
            if (match(reg_idx_t'(w_idx_e), w_use_e, reg_idx_t'(rd_m), regwrite_m)) begin
                w_sel = FWD_M;
            end else if (match(reg_idx_t'(w_idx_e), w_use_e, reg_idx_t'(rd_w), regwrite_w)) begin
                w_sel = FWD_W;
            end
        end

        assign fwd_sel_e[k*2 +: 2] = reset ? w_sel : FWD_RF;

        assign w_lu_hit[k] = match(reg_idx_t'(src_idx_d[k*RW +: RW]), src_vld_d[k],
                                   reg_idx_t'(rd_e), regwrite_e);
    end

    assign w_ldstall = memtoreg_e && (|w_lu_hit);
    assign w_pcpend  = pcsrc_d || pcsrc_e || pcsrc_m;

    // Multicycle hold outranks branch flush, which outranks load-use and PC-write pending.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            stall_f = 1'b0;
        end else if (w_mc_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = !w_mc_done;
        end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            stall_f = w_ldstall || w_pcpend;
            stall_d = w_ldstall;
            flush_e = w_ldstall;
            flush_d = w_pcpend || pcsrc_w;
        end
    end

    assign mc_busy = reset && w_mc_busy;
    assign mc_done = reset && w_mc_done;

    a_mc_branch_excl: assert property (@(posedge clk) disable iff (!reset)
                                       !(mc_start_e && branch_taken_e));

endmodule

// File: tb/tb_hazard_unit_param.sv
// Bench for hazard_unit_param: constant vector table, hand sequences, random vs model.
module tb_hazard_unit_param;

    localparam int RW     = 4;
    localparam int NSRC   = 3;
    localparam int MC_LAT = 4;
    localparam int PC_IDX = 15;

    typedef struct packed {
        logic [NSRC*RW-1:0] src_idx_d;
        logic [NSRC-1:0]    src_vld_d;
        logic [NSRC*RW-1:0] src_idx_e;
        logic [NSRC-1:0]    src_vld_e;
        logic [RW-1:0]      rd_e;
        logic               regwrite_e;
        logic               memtoreg_e;
        logic               mc_start_e;
        logic [RW-1:0]      rd_m;
        logic               regwrite_m;
        logic [RW-1:0]      rd_w;
        logic               regwrite_w;
        logic               pcsrc_d;
        logic               pcsrc_e;
        logic               pcsrc_m;
        logic               pcsrc_w;
        logic               branch_taken_e;
    } in_t;

    typedef struct packed {
        logic [NSRC*2-1:0] fwd;
        logic sf, sd, se, fd, fe, busy, done;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic               clk;
    logic               reset;
    logic [NSRC*RW-1:0] src_idx_d, src_idx_e;
    logic [NSRC-1:0]    src_vld_d, src_vld_e;
    logic [RW-1:0]      rd_e, rd_m, rd_w;
    logic               regwrite_e, memtoreg_e, mc_start_e, regwrite_m, regwrite_w;
    logic               pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e;
    logic [NSRC*2-1:0]  fwd_sel_e;
    logic               stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy, mc_done;

    int n_chk  = 0;
    int n_fail = 0;
    int m_pos  = 0;   // model: position inside the current multicycle window, 0 = none

    hazard_unit_param #(
        .RW(RW), .NSRC(NSRC), .MC_LAT(MC_LAT), .PC_IDX(PC_IDX)
    ) dut (
        .clk(clk), .reset(reset),
        .src_idx_d(src_idx_d), .src_vld_d(src_vld_d),
        .src_idx_e(src_idx_e), .src_vld_e(src_vld_e),
        .rd_e(rd_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .mc_start_e(mc_start_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .pcsrc_d(pcsrc_d), .pcsrc_e(pcsrc_e), .pcsrc_m(pcsrc_m), .pcsrc_w(pcsrc_w),
        .branch_taken_e(branch_taken_e),
        .fwd_sel_e(fwd_sel_e), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .mc_busy(mc_busy), .mc_done(mc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input in_t v);
        src_idx_d = v.src_idx_d;  src_vld_d = v.src_vld_d;
        src_idx_e = v.src_idx_e;  src_vld_e = v.src_vld_e;
        rd_e = v.rd_e;  regwrite_e = v.regwrite_e;  memtoreg_e = v.memtoreg_e;
        mc_start_e = v.mc_start_e;
        rd_m = v.rd_m;  regwrite_m = v.regwrite_m;
        rd_w = v.rd_w;  regwrite_w = v.regwrite_w;
        pcsrc_d = v.pcsrc_d;  pcsrc_e = v.pcsrc_e;  pcsrc_m = v.pcsrc_m;  pcsrc_w = v.pcsrc_w;
        branch_taken_e = v.branch_taken_e;
    endtask

    function automatic out_t mk(input logic sf, sd, se, fd, fe, bz, dn);
        out_t o;
        o = '0;
        o.sf = sf; o.sd = sd; o.se = se; o.fd = fd; o.fe = fe; o.busy = bz; o.done = dn;
        return o;
    endfunction

    task automatic chk(input string nm, input out_t exp);
        out_t act;
        act = {fwd_sel_e, stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy, mc_done};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got fwd=%b sf/sd/se/fd/fe/busy/done=%b, expected fwd=%b %b",
                     nm, act.fwd, act[6:0], exp.fwd, exp[6:0]);
        end
    endtask

    task automatic step(input in_t v, input out_t exp, input string nm);
        @(negedge clk);
        apply(v);
        #1;
        chk(nm, exp);
    endtask

    // Reference model: rules applied directly, multicycle tracked as a window position.
    function automatic out_t model(input in_t v, input int pos);
        out_t o;
        logic [RW-1:0] idx;
        bit ld, pcp;
        o = '0;
        ld = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = v.src_idx_e[k*RW +: RW];
            if (v.src_vld_e[k] && idx != RW'(PC_IDX)) begin
                if (v.regwrite_m && v.rd_m == idx)      o.fwd[2*k +: 2] = 2'b10;
                else if (v.regwrite_w && v.rd_w == idx) o.fwd[2*k +: 2] = 2'b01;
            end
            if (v.memtoreg_e && v.regwrite_e && v.src_vld_d[k] &&
                v.src_idx_d[k*RW +: RW] == v.rd_e) ld = 1;
        end
        pcp = v.pcsrc_d || v.pcsrc_e || v.pcsrc_m;
        if (pos != 0) begin
            o.busy = 1; o.done = (pos == MC_LAT);
            o.sf = 1; o.sd = 1; o.se = (pos < MC_LAT);
        end else if (v.branch_taken_e) begin
            o.fd = 1; o.fe = 1;
        end else begin
            o.sf = ld || pcp; o.sd = ld; o.fe = ld; o.fd = pcp || v.pcsrc_w;
        end
        return o;
    endfunction

    function automatic logic [RW-1:0] rnd_idx();
        int r;
        r = $urandom_range(0, 9);
        return (r >= 8) ? RW'(PC_IDX) : RW'(r);
    endfunction

    initial begin
        vec_t tbl[12];
        vec_t t;
        in_t  v;
        out_t e;
        int   pos;

        reset = 1'b0;
        v = '0;
        apply(v);

        // Reset: outputs cleared even with a start request and a forwarding hit present.
        step(v, '0, "reset_idle");
        v.mc_start_e = 1; v.src_idx_e = 12'h003; v.src_vld_e = 3'b001; v.rd_m = 3; v.regwrite_m = 1;
        step(v, '0, "reset_gated");
        @(negedge clk);
        v = '0;
        apply(v);
        reset = 1'b1;

        t.i = '0; t.o = '0;
        t.i.src_idx_e = 12'h003; t.i.src_vld_e = 3'b001;
        t.i.rd_m = 3; t.i.regwrite_m = 1; t.i.rd_w = 3; t.i.regwrite_w = 1;
        t.o.fwd = 6'b000010;                                   tbl[0] = t;
        t.i.regwrite_m = 0; t.o.fwd = 6'b000001;               tbl[1] = t;
        t.i.regwrite_m = 1; t.i.src_idx_e = 12'h00F; t.o.fwd = '0; tbl[2] = t;
        t.i = '0; t.o = '0;
        t.i.src_idx_e = 12'h730; t.i.src_vld_e = 3'b110;
        t.i.rd_m = 7; t.i.regwrite_m = 1; t.i.rd_w = 3; t.i.regwrite_w = 1;
        t.o.fwd = 6'b100100;                                   tbl[3] = t;
        t.i.src_vld_e = 3'b010; t.o.fwd = 6'b000100;           tbl[4] = t;
        t.i = '0;
        t.i.memtoreg_e = 1; t.i.regwrite_e = 1; t.i.rd_e = 5;
        t.i.src_idx_d = 12'h050; t.i.src_vld_d = 3'b010;
        t.o = mk(1, 1, 0, 0, 1, 0, 0);                         tbl[5] = t;
        t.i.src_vld_d = 3'b000; t.o = '0;                      tbl[6] = t;
        t.i.src_vld_d = 3'b010; t.i.regwrite_e = 0;            tbl[7] = t;
        t.i.regwrite_e = 1; t.i.branch_taken_e = 1;
        t.o = mk(0, 0, 0, 1, 1, 0, 0);                         tbl[8] = t;
        t.i = '0; t.i.pcsrc_e = 1; t.o = mk(1, 0, 0, 1, 0, 0, 0); tbl[9] = t;
        t.i = '0; t.i.pcsrc_w = 1; t.o = mk(0, 0, 0, 1, 0, 0, 0); tbl[10] = t;
        t.i = '0;
        t.i.memtoreg_e = 1; t.i.regwrite_e = 1; t.i.rd_e = 5;
        t.i.src_idx_d = 12'h500; t.i.src_vld_d = 3'b100; t.i.pcsrc_d = 1;
        t.o = mk(1, 1, 0, 1, 1, 0, 0);                         tbl[11] = t;

        for (int n = 0; n < 12; n++) begin
            step(tbl[n].i, tbl[n].o, $sformatf("vec[%0d]", n));
        end

        // Load-use bubble lasts a single cycle once the load moves on.
        v = tbl[5].i;
        step(v, mk(1, 1, 0, 0, 1, 0, 0), "ldu_c1");
        v = '0;
        step(v, '0, "ldu_c2");

        // Multicycle: two back-to-back windows, hazards masked while busy.
        v = '0; v.mc_start_e = 1;
        step(v, mk(1, 1, 1, 0, 0, 1, 0), "mc_c1");
        v = tbl[5].i; v.pcsrc_d = 1;
        step(v, mk(1, 1, 1, 0, 0, 1, 0), "mc_c2_masked");
        v = '0;
        step(v, mk(1, 1, 1, 0, 0, 1, 0), "mc_c3");
        step(v, mk(1, 1, 0, 0, 0, 1, 1), "mc_c4_done");
        v.mc_start_e = 1;
        step(v, mk(1, 1, 1, 0, 0, 1, 0), "mc_c5_restart");
        v = '0;
        step(v, mk(1, 1, 1, 0, 0, 1, 0), "mc_c6");
        step(v, mk(1, 1, 1, 0, 0, 1, 0), "mc_c7");
        step(v, mk(1, 1, 0, 0, 0, 1, 1), "mc_c8_done");
        v = tbl[5].i;
        step(v, mk(1, 1, 0, 0, 1, 0, 0), "mc_c9_ldu_reeval");

        // PC write walking D -> E -> M -> W.
        v = '0; v.pcsrc_d = 1; step(v, mk(1, 0, 0, 1, 0, 0, 0), "pc_d");
        v = '0; v.pcsrc_e = 1; step(v, mk(1, 0, 0, 1, 0, 0, 0), "pc_e");
        v = '0; v.pcsrc_m = 1; step(v, mk(1, 0, 0, 1, 0, 0, 0), "pc_m");
        v = '0; v.pcsrc_w = 1; step(v, mk(0, 0, 0, 1, 0, 0, 0), "pc_w");
        v = '0;                step(v, '0, "pc_done");

        // Reset asserted in the second busy cycle.
        v = '0; v.mc_start_e = 1;
        step(v, mk(1, 1, 1, 0, 0, 1, 0), "rst_mc_c1");
        v = '0; v.src_idx_e = 12'h003; v.src_vld_e = 3'b001; v.rd_m = 3; v.regwrite_m = 1; v.pcsrc_d = 1;
        e = mk(1, 1, 1, 0, 0, 1, 0); e.fwd = 6'b000010;
        step(v, e, "rst_mc_c2");
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mc_async", '0);
        @(negedge clk);
        v = '0;
        apply(v);
        reset = 1'b1;
        for (int n = 0; n < MC_LAT + 2; n++) begin
            step(v, '0, $sformatf("post_rst[%0d]", n));
        end

        // Random traffic against the model.
        m_pos = 0;
        for (int n = 0; n < 400; n++) begin
            v = '0;
            for (int k = 0; k < NSRC; k++) begin
                v.src_idx_d[k*RW +: RW] = rnd_idx();
                v.src_idx_e[k*RW +: RW] = rnd_idx();
            end
            v.src_vld_d  = 3'($urandom_range(0, 7));
            v.src_vld_e  = 3'($urandom_range(0, 7));
            v.rd_e = rnd_idx(); v.rd_m = rnd_idx(); v.rd_w = rnd_idx();
            v.regwrite_e = 1'($urandom_range(0, 1));
            v.memtoreg_e = 1'($urandom_range(0, 1));
            v.regwrite_m = 1'($urandom_range(0, 1));
            v.regwrite_w = 1'($urandom_range(0, 1));
            v.mc_start_e = ($urandom_range(0, 7) == 0);
            v.branch_taken_e = !v.mc_start_e && ($urandom_range(0, 7) == 0);
            v.pcsrc_d = ($urandom_range(0, 5) == 0);
            v.pcsrc_e = ($urandom_range(0, 5) == 0);
            v.pcsrc_m = ($urandom_range(0, 5) == 0);
            v.pcsrc_w = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            apply(v);
            #1;
            pos = (m_pos != 0) ? m_pos : (v.mc_start_e ? 1 : 0);
            chk($sformatf("rand[%0d]", n), model(v, pos));
            m_pos = (pos == 0 || pos == MC_LAT) ? 0 : pos + 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
